booth_seq_multiplier: RTL and testbench

BOOTH_SEQ_MULTIPLIER -- requirements
Module: booth_seq_multiplier

---
 rtl/booth_pkg.sv | 9 +
 rtl/booth_digit_recoder.sv | 13 +
 rtl/booth_seq_multiplier.sv | 68 ++++++
 tb/tb_booth_seq_multiplier.sv | 136 +++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM state and Booth digit encoding for the sequential multiplier
package booth_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef struct packed {
    logic zero;
    logic neg;
    logic two;
  } booth_digit_t;
endpackage

// File: rtl/booth_digit_recoder.sv
// booth_digit_recoder: radix-4 Booth digit to {zero, neg, two}
module booth_digit_recoder
  import booth_pkg::*;
(
  input  logic [2:0]   digit,
  output booth_digit_t rec
);
  always_comb begin
    rec.zero = (digit == 3'b000) || (digit == 3'b111);
    rec.neg  = digit[2];
    rec.two  = (digit == 3'b011) || (digit == 3'b100);
  end
endmodule

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: one radix-4 Booth digit per cycle, signed or unsigned operands
module booth_seq_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);
  localparam int NDIG = WIDTH / 2 + 1;
  localparam int ACCW = 2 * WIDTH + 4;
  localparam int CW   = $clog2(NDIG + 1);
  state_t             state, state_n;
  logic [CW-1:0]      cnt;
  logic [ACCW-1:0]    acc, mcand, pp_mag, pp;
  logic [WIDTH+2:0]   bsh;
  logic [2*WIDTH-1:0] prod_r;
  logic               last;
  booth_digit_t       dig;
  booth_digit_recoder u_rec (.digit(bsh[2:0]), .rec(dig));
  assign last      = cnt == CW'(NDIG);
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = state == DONE;
  assign product   = prod_r;
  always_comb begin
    pp_mag  = dig.two ? mcand << 1 : mcand;
    pp      = dig.zero ? '0 : dig.neg ? -pp_mag : pp_mag;
    state_n = state == IDLE ? (in_valid ? CALC : IDLE) :
              state == CALC ? (last ? DONE : CALC) :
              (out_ready ? IDLE : DONE);
  end
  // multiplicand shifts by 2 each digit so the partial product lands at weight 4^i;
  // one extra CALC cycle with cnt == NDIG registers the product
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      bsh    <= '0;
      prod_r <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        mcand <= {{(ACCW-WIDTH){is_signed & a[WIDTH-1]}}, a};
        bsh   <= {{2{is_signed & b[WIDTH-1]}}, b, 1'b0};
        acc   <= '0;
        cnt   <= '0;
      end else if (state == CALC) begin
        if (last) prod_r <= acc[2*WIDTH-1:0];
        else begin
          acc   <= acc + pp;
          mcand <= mcand << 2;
          bsh   <= bsh >> 2;
          cnt   <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb_booth_seq_multiplier: directed and randomized checks of the Booth multiplier
module tb_booth_seq_multiplier;
  logic        clk = 0, rst, in_valid, in_ready, is_signed, out_valid, out_ready;
  logic [15:0] a, b;
  logic [31:0] product;
  int          pass_cnt = 0, total = 0;

  booth_seq_multiplier #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .is_signed(is_signed), .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input logic s);
    logic [31:0] xe, ye;
    xe = {{16{s & x[15]}}, x};
    ye = {{16{s & y[15]}}, y};
    return xe * ye;
  endfunction

  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic s, input int gap,
                       input int hold, output logic [31:0] p, output int lat);
    in_valid = 0;
    repeat (gap) begin @(posedge clk); #1; end
    a = x; b = y; is_signed = s; in_valid = 1;
    @(posedge clk); #1;
    a = 16'($urandom); b = 16'($urandom); is_signed = 1'($urandom); in_valid = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
      in_valid = 1'($urandom); out_ready = 1'($urandom);
    end
    out_ready = 0;
    p = product;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1; in_valid = 0;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; out_ready = 0; a = 0; b = 0; is_signed = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total++; if (product !== 32'h0) $display("FAIL reset_product got %h want 0", product); else pass_cnt++;
    rst = 0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [15:0] xs [8] = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h1234};
    logic [15:0] ys [8] = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0001, 16'h8000, 16'h8000, 16'h0010};
    logic        ss [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] es [8] = '{32'h4000_0000, 32'hFFFE_0001, 32'h0000_0001, 32'hFFFF_FFFF,
                            32'h0000_FFFF, 32'h4000_0000, 32'hC000_8000, 32'h0001_2340};
    logic [31:0] p;
    int lat;
    for (int i = 0; i < 8; i++) begin
      do_op(xs[i], ys[i], ss[i], 0, 0, p, lat);
      total++; if (p !== es[i]) $display("FAIL directed_%0d product got %h want %h", i, p, es[i]); else pass_cnt++;
      total++; if (lat !== 10) $display("FAIL directed_%0d latency got %0d want 10", i, lat); else pass_cnt++;
      total++; if (product !== es[i]) $display("FAIL directed_%0d idle_hold got %h want %h", i, product, es[i]); else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    int n;
    a = 16'h0003; b = 16'hFFFE; is_signed = 1; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    total++; if (n !== 10) $display("FAIL stall_latency got %0d want 10", n); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; a = 16'h0007; b = 16'h0009; is_signed = 0;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) $display("FAIL stall_out_valid_%0d got %b want 1", i, out_valid); else pass_cnt++;
      total++; if (product !== 32'hFFFF_FFFA) $display("FAIL stall_product_%0d got %h want fffffffa", i, product); else pass_cnt++;
      total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready_%0d got %b want 0", i, in_ready); else pass_cnt++;
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0; in_valid = 0;
    total++; if (in_ready !== 1'b1) $display("FAIL stall_release_in_ready got %b want 1", in_ready); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("FAIL stall_release_out_valid got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid_calc();
    logic [31:0] p;
    int lat, seen;
    a = 16'h1111; b = 16'h2222; is_signed = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; seen = 0;
    repeat (3) begin @(posedge clk); #1; seen |= int'(out_valid); end
    rst = 1;
    @(posedge clk); #1;
    seen |= int'(out_valid);
    rst = 0;
    #1;
    total++; if (product !== 32'h0) $display("FAIL abort_product got %h want 0", product); else pass_cnt++;
    total++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready got %b want 1", in_ready); else pass_cnt++;
    repeat (12) begin @(posedge clk); #1; seen |= int'(out_valid); end
    total++; if (seen !== 0) $display("FAIL abort_out_valid got %0d want 0", seen); else pass_cnt++;
    do_op(16'd3, 16'd5, 1'b0, 0, 0, p, lat);
    total++; if (p !== 32'h0000_000F) $display("FAIL abort_followup got %h want 0000000f", p); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [15:0] x, y;
    logic        s;
    logic [31:0] p, e;
    int lat;
    for (int i = 0; i < 4000; i++) begin
      x = 16'($urandom); y = 16'($urandom); s = 1'($urandom);
      e = ref_mul(x, y, s);
      do_op(x, y, s, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), p, lat);
      total++;
      if (p !== e || lat !== 10)
        $display("FAIL random_%0d a=%h b=%h s=%b got %h lat %0d want %h lat 10", i, x, y, s, p, lat, e);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid_calc();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
